stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Run/pause/lap controller for the MM:SS stopwatch digit chain: d0 mod-10, d1 mod-6 (counter_0to5),
//  d2 mod-10, d3 mod-6. Owns the 1 Hz prescaler, the button front end and the start/stop FSM.
//  Drives per-digit enables and a common synchronous clear. Reads per-digit terminal-count flags,
//  never the combinational carry_out, so there is no ena->carry->ena loop.
// PARAMETERS
//  PRESCALE   50_000_000  clk cycles per count tick (1 Hz at 50 MHz); bench uses 4
//  PS_W       26          prescaler width; must satisfy 2**PS_W >= PRESCALE
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  clr_n      in   1  reset, asynchronous, active-low
//  btn_start  in   1  start/stop pushbutton, asynchronous level
//  btn_lap    in   1  lap pushbutton, asynchronous level
//  btn_reset  in   1  zero pushbutton, asynchronous level
//  tc         in   4  terminal count; tc[i]=1 when digit i is at max (9 or 5)
//  dig_ena    out  4  per-digit count enable, registered
//  dig_clr    out  1  synchronous clear to all four digits, registered
//  lap_hold   out  1  freeze display latches (counting continues)
//  running    out  1  1 in RUN or LAP
//  ovf        out  1  one-cycle pulse when 59:59 wraps to 00:00
// BEHAVIOUR
//  Reset (clr_n=0): state=IDLE, prescaler=0, sync/edge flops=0, all outputs 0, immediately.
//  First clk edge after clr_n rises: dig_clr=1 for exactly one cycle (init clear of digits).
//  Buttons: 2-FF synchronizer + rising-edge detect per button. A level that rises before clk
//   edge k acts on state at edge k+2. A held button gives exactly one event.
//  FSM states IDLE, RUN, LAP, PAUSE. Edge priority per cycle: reset > start > lap.
//   IDLE : start -> RUN. reset -> IDLE plus dig_clr pulse. lap ignored.
//   RUN  : start -> PAUSE. lap -> LAP. reset ignored.
//   LAP  : start -> PAUSE. lap -> RUN. reset ignored.
//   PAUSE: start -> RUN. reset -> IDLE plus one-cycle dig_clr. lap ignored.
//  lap_hold=1 exactly while state==LAP. running=1 while RUN or LAP.
//  Prescaler: increments each cycle in RUN/LAP. Wraps PRESCALE-1 -> 0.
//   Holds its value in PAUSE. Forced to 0 in IDLE and on any dig_clr.
//  tick = (state in RUN/LAP) && prescaler==PRESCALE-1.
//   dig_ena[0]=tick. dig_ena[i]=tick && &tc[i-1:0] for i=1..3.
//  ovf=tick && &tc. The digits wrap on their own; the controller does not assert dig_clr for ovf.
//  Outputs are registered: dig_ena/ovf appear the cycle after tick is computed, one pulse per tick.
//  Invariant: dig_clr=1 implies dig_ena=4'b0000. Required because counter_0to5 loads 5 when
//   clr&ena are both 1.
//  Going from RUN to PAUSE on a tick cycle: that tick's dig_ena is still issued. No tick is
//   issued afterwards until RUN.
// TESTING (PRESCALE=4)
//  1 reset, pulse btn_start -> running=1 at 3rd edge; dig_ena=0001 every 4 cycles, none in between.
//  2 RUN, tc=0011 at tick -> dig_ena=0111, ovf=0. tc=1111 at tick -> dig_ena=1111, ovf=1 for 1 cycle.
//  3 pause at prescaler=2, wait 10 cycles -> no dig_ena. Resume -> first dig_ena 2 cycles after RUN.
//  4 lap in RUN -> lap_hold=1 and ticks continue. Lap again -> lap_hold=0. Start in LAP -> PAUSE, lap_hold=0.
//  5 btn_reset in RUN -> no effect. In PAUSE -> IDLE, dig_clr=1 one cycle, dig_ena=0, running=0.
//  6 clr_n low mid-RUN -> all outputs 0 at once. Release -> one dig_clr, state IDLE; start+lap same cycle -> RUN.

Source files
------------

// File: rtl/stopwatch_if.sv
// Signal bundle between the stopwatch controller and its digit chain / button front panel.
// The slave side is the controller; the master side drives buttons and terminal counts.
interface stopwatch_if;
  logic       btn_start;
  logic       btn_lap;
  logic       btn_reset;
  logic [3:0] tc;
  logic [3:0] dig_ena;
  logic       dig_clr;
  logic       lap_hold;
  logic       running;
  logic       ovf;

  modport master (
    output btn_start, btn_lap, btn_reset, tc,
    input  dig_ena, dig_clr, lap_hold, running, ovf
  );

  modport slave (
    input  btn_start, btn_lap, btn_reset, tc,
    output dig_ena, dig_clr, lap_hold, running, ovf
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap controller for an MM:SS digit chain: prescaler, button front end and FSM.
// Digit enables are built from registered terminal-count flags, never from carry_out.
module stopwatch_ctrl #(
  parameter int unsigned PRESCALE = 50_000_000,
  parameter int unsigned PS_W     = 26
) (
  input  logic       clk,
  input  logic       clr_n,
  stopwatch_if.slave sw
);

  typedef enum logic [1:0] {StIdle, StRun, StLap, StPause} state_e;

  localparam logic [PS_W-1:0] PsLast = PS_W'(PRESCALE - 1);

  state_e          state_q, state_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [2:0]      btn_raw, sync1_q, sync2_q, prev_q, btn_rise;
  logic            init_q;
  logic [3:0]      dig_ena_q, dig_ena_d;
  logic            dig_clr_q, dig_clr_d;
  logic            ovf_q, ovf_d;
  logic            counting, tick;
  logic            rise_start, rise_lap, rise_reset;

  // Button bits packed as {reset, lap, start}.
  assign btn_raw    = {sw.btn_reset, sw.btn_lap, sw.btn_start};
  assign btn_rise   = sync2_q & ~prev_q;
  assign rise_start = btn_rise[0];
  assign rise_lap   = btn_rise[1];
  assign rise_reset = btn_rise[2];

  assign counting = (state_q == StRun) || (state_q == StLap);
  assign tick     = counting && (ps_q == PsLast);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    // Pending init clear is issued on the first edge after reset release.
    dig_clr_d = init_q;
    unique case (state_q)
      StIdle: begin
        if (rise_reset) begin
          dig_clr_d = 1'b1;
        end else if (rise_start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (rise_start) begin
          state_d = StPause;
        end else if (rise_lap) begin
          state_d = StLap;
        end
      end
      StLap: begin
        if (rise_start) begin
          state_d = StPause;
        end else if (rise_lap) begin
          state_d = StRun;
        end
      end
      StPause: begin
        if (rise_reset) begin
          state_d   = StIdle;
          dig_clr_d = 1'b1;
        end else if (rise_start) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ps_d = ps_q;
    if ((state_q == StIdle) || dig_clr_d) begin
      ps_d = '0;
    end else if (counting) begin
      ps_d = (ps_q == PsLast) ? '0 : ps_q + PS_W'(1);
    end
  end

  always_comb begin
    dig_ena_d = {tick & (&sw.tc[2:0]), tick & (&sw.tc[1:0]), tick & sw.tc[0], tick};
    ovf_d     = tick & (&sw.tc);
    // counter_0to5 misbehaves when clr and ena coincide, so clear always wins.
    if (dig_clr_d) begin
      dig_ena_d = '0;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= StIdle;
      ps_q      <= '0;
      init_q    <= 1'b1;
      dig_ena_q <= '0;
      dig_clr_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ps_q      <= ps_d;
      init_q    <= 1'b0;
      dig_ena_q <= dig_ena_d;
      dig_clr_q <= dig_clr_d;
      ovf_q     <= ovf_d;
    end
  end

  assign sw.dig_ena  = dig_ena_q;
  assign sw.dig_clr  = dig_clr_q;
  assign sw.ovf      = ovf_q;
  assign sw.running  = counting;
  assign sw.lap_hold = (state_q == StLap);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with PRESCALE=4: expected output pulses are queued
// as stimulus is applied and matched against pulses recorded from the DUT.
module tb_stopwatch_ctrl;

  typedef struct packed {
    int unsigned cyc;
    logic [3:0]  ena;
    logic        ovf;
    logic        clr;
  } ev_t;

  logic        clk   = 1'b0;
  logic        clr_n = 1'b0;
  int unsigned cyc   = 0;
  int          checks = 0;
  int          errors = 0;
  int unsigned next_tick = 0;
  int unsigned remaining = 0;
  ev_t         exp_q[$];
  ev_t         obs_q[$];

  stopwatch_if sw();

  stopwatch_ctrl #(
    .PRESCALE (4),
    .PS_W     (3)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .sw    (sw)
  );

  always #5 clk = ~clk;

  // cyc counts rising edges; at a falling edge it equals the index of the last rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sw.dig_ena != 4'b0000 || sw.ovf || sw.dig_clr) begin
      obs_q.push_back('{cyc: cyc, ena: sw.dig_ena, ovf: sw.ovf, clr: sw.dig_clr});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  // Rising level before edge cyc+1 acts on the FSM at edge cyc+3.
  task automatic press(input logic s, input logic l, input logic r, input int hold,
                       output int unsigned act);
    act          = cyc + 3;
    sw.btn_start = s;
    sw.btn_lap   = l;
    sw.btn_reset = r;
    repeat (hold) @(negedge clk);
    sw.btn_start = 1'b0;
    sw.btn_lap   = 1'b0;
    sw.btn_reset = 1'b0;
  endtask

  task automatic push_ev(input int unsigned c, input logic [3:0] e, input logic o,
                         input logic k);
    exp_q.push_back('{cyc: c, ena: e, ovf: o, clr: k});
  endtask

  task automatic push_ticks(input int unsigned limit);
    while (next_tick <= limit) begin
      push_ev(next_tick, 4'b0001, 1'b0, 1'b0);
      next_tick += 4;
    end
  endtask

  task automatic test_reset();
    ev_t         e, o;
    int unsigned c;
    repeat (3) @(negedge clk);
    checks++;
    if ({sw.dig_ena, sw.dig_clr, sw.running, sw.lap_hold, sw.ovf} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got ena=%b clr=%b run=%b lap=%b ovf=%b required all 0",
               sw.dig_ena, sw.dig_clr, sw.running, sw.lap_hold, sw.ovf);
    end
    c     = cyc;
    clr_n = 1'b1;
    push_ev(c + 1, 4'b0000, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (sw.dig_clr !== 1'b1) begin
      errors++;
      $display("FAIL init_clr got %b required 1", sw.dig_clr);
    end
    @(negedge clk);
    checks++;
    if (sw.dig_clr !== 1'b0 || sw.running !== 1'b0) begin
      errors++;
      $display("FAIL init_clr_end got clr=%b run=%b required 0 0", sw.dig_clr, sw.running);
    end
    wait_until(c + 5);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = '0;
      o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_events got cyc=%0d ena=%b ovf=%b clr=%b required cyc=%0d ena=%b ovf=%b clr=%b",
                 o.cyc, o.ena, o.ovf, o.clr, e.cyc, e.ena, e.ovf, e.clr);
      end
    end
  endtask

  task automatic test_run();
    ev_t         e, o;
    int unsigned r;
    sw.tc = 4'b0000;
    press(1'b1, 1'b0, 1'b0, 1, r);
    wait_until(r - 1);
    checks++;
    if (sw.running !== 1'b0) begin
      errors++;
      $display("FAIL run_early got running=%b required 0", sw.running);
    end
    wait_until(r);
    checks++;
    if (sw.running !== 1'b1 || sw.lap_hold !== 1'b0) begin
      errors++;
      $display("FAIL run_start got run=%b lap=%b required 1 0", sw.running, sw.lap_hold);
    end
    next_tick = r + 4;
    push_ticks(r + 12);
    wait_until(r + 14);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = '0;
      o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL run_events got cyc=%0d ena=%b ovf=%b clr=%b required cyc=%0d ena=%b ovf=%b clr=%b",
                 o.cyc, o.ena, o.ovf, o.clr, e.cyc, e.ena, e.ovf, e.clr);
      end
    end
  endtask

  task automatic test_carry();
    ev_t         e, o;
    int unsigned n;
    n = next_tick;
    wait_until(n - 1);
    sw.tc = 4'b0011;
    wait_until(n);
    sw.tc = 4'b0000;
    push_ev(n, 4'b0111, 1'b0, 1'b0);
    wait_until(n + 3);
    sw.tc = 4'b1111;
    wait_until(n + 4);
    sw.tc = 4'b0000;
    push_ev(n + 4, 4'b1111, 1'b1, 1'b0);
    next_tick = n + 8;
    checks++;
    if (sw.ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pulse got %b required 1", sw.ovf);
    end
    wait_until(n + 5);
    checks++;
    if (sw.ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_width got %b required 0", sw.ovf);
    end
    wait_until(n + 6);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = '0;
      o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL carry_events got cyc=%0d ena=%b ovf=%b clr=%b required cyc=%0d ena=%b ovf=%b clr=%b",
                 o.cyc, o.ena, o.ovf, o.clr, e.cyc, e.ena, e.ovf, e.clr);
      end
    end
  endtask

  task automatic test_pause();
    ev_t         e, o;
    int unsigned n, p, r;
    n = next_tick;
    // Pause lands two edges after a tick, leaving the prescaler at 2.
    wait_until(n - 1);
    push_ticks(n);
    press(1'b1, 1'b0, 1'b0, 1, p);
    remaining = next_tick - p;
    wait_until(p);
    checks++;
    if (sw.running !== 1'b0 || sw.lap_hold !== 1'b0) begin
      errors++;
      $display("FAIL pause_state got run=%b lap=%b required 0 0", sw.running, sw.lap_hold);
    end
    wait_until(p + 10);
    press(1'b1, 1'b0, 1'b0, 1, r);
    next_tick = r + remaining;
    wait_until(r);
    checks++;
    if (sw.running !== 1'b1) begin
      errors++;
      $display("FAIL resume_state got running=%b required 1", sw.running);
    end
    push_ticks(r + 6);
    wait_until(r + 8);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = '0;
      o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL pause_events got cyc=%0d ena=%b ovf=%b clr=%b required cyc=%0d ena=%b ovf=%b clr=%b",
                 o.cyc, o.ena, o.ovf, o.clr, e.cyc, e.ena, e.ovf, e.clr);
      end
    end
  endtask

  task automatic test_lap();
    ev_t         e, o;
    int unsigned l1, l2, l3, pz;
    // Held for several cycles: must still count as a single lap event.
    press(1'b0, 1'b1, 1'b0, 6, l1);
    checks++;
    if (sw.lap_hold !== 1'b1 || sw.running !== 1'b1) begin
      errors++;
      $display("FAIL lap_enter got lap=%b run=%b required 1 1", sw.lap_hold, sw.running);
    end
    wait_until(l1 + 5);
    press(1'b0, 1'b1, 1'b0, 1, l2);
    wait_until(l2);
    checks++;
    if (sw.lap_hold !== 1'b0 || sw.running !== 1'b1) begin
      errors++;
      $display("FAIL lap_exit got lap=%b run=%b required 0 1", sw.lap_hold, sw.running);
    end
    press(1'b0, 1'b1, 1'b0, 1, l3);
    wait_until(l3);
    checks++;
    if (sw.lap_hold !== 1'b1) begin
      errors++;
      $display("FAIL lap_again got lap=%b required 1", sw.lap_hold);
    end
    wait_until(l3 + 2);
    press(1'b1, 1'b0, 1'b0, 1, pz);
    wait_until(pz);
    checks++;
    if (sw.lap_hold !== 1'b0 || sw.running !== 1'b0) begin
      errors++;
      $display("FAIL lap_pause got lap=%b run=%b required 0 0", sw.lap_hold, sw.running);
    end
    push_ticks(pz);
    remaining = next_tick - pz;
    wait_until(pz + 6);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = '0;
      o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL lap_events got cyc=%0d ena=%b ovf=%b clr=%b required cyc=%0d ena=%b ovf=%b clr=%b",
                 o.cyc, o.ena, o.ovf, o.clr, e.cyc, e.ena, e.ovf, e.clr);
      end
    end
  endtask

  task automatic test_reset_btn();
    ev_t         e, o;
    int unsigned r, x, p, i;
    press(1'b1, 1'b0, 1'b0, 1, r);
    next_tick = r + remaining;
    wait_until(r);
    press(1'b0, 1'b0, 1'b1, 1, x);
    wait_until(x + 1);
    checks++;
    if (sw.running !== 1'b1 || sw.dig_clr !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_run got run=%b clr=%b required 1 0", sw.running, sw.dig_clr);
    end
    press(1'b1, 1'b0, 1'b0, 1, p);
    push_ticks(p);
    wait_until(p);
    checks++;
    if (sw.running !== 1'b0) begin
      errors++;
      $display("FAIL reset_pause got running=%b required 0", sw.running);
    end
    press(1'b0, 1'b0, 1'b1, 1, i);
    push_ev(i, 4'b0000, 1'b0, 1'b1);
    wait_until(i);
    checks++;
    if (sw.dig_clr !== 1'b1 || sw.dig_ena !== 4'b0000 || sw.running !== 1'b0) begin
      errors++;
      $display("FAIL reset_to_idle got clr=%b ena=%b run=%b required 1 0000 0",
               sw.dig_clr, sw.dig_ena, sw.running);
    end
    wait_until(i + 1);
    checks++;
    if (sw.dig_clr !== 1'b0) begin
      errors++;
      $display("FAIL reset_clr_width got %b required 0", sw.dig_clr);
    end
    wait_until(i + 4);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = '0;
      o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL resetbtn_events got cyc=%0d ena=%b ovf=%b clr=%b required cyc=%0d ena=%b ovf=%b clr=%b",
                 o.cyc, o.ena, o.ovf, o.clr, e.cyc, e.ena, e.ovf, e.clr);
      end
    end
  endtask

  task automatic test_async_reset();
    ev_t         e, o;
    int unsigned r, c;
    press(1'b1, 1'b0, 1'b0, 1, r);
    next_tick = r + 4;
    wait_until(next_tick);
    push_ev(next_tick, 4'b0001, 1'b0, 1'b0);
    #1 clr_n = 1'b0;
    #1;
    checks++;
    if ({sw.dig_ena, sw.dig_clr, sw.running, sw.lap_hold, sw.ovf} !== 8'h00) begin
      errors++;
      $display("FAIL async_clear got ena=%b clr=%b run=%b lap=%b ovf=%b required all 0",
               sw.dig_ena, sw.dig_clr, sw.running, sw.lap_hold, sw.ovf);
    end
    repeat (3) @(negedge clk);
    c     = cyc;
    clr_n = 1'b1;
    push_ev(c + 1, 4'b0000, 1'b0, 1'b1);
    press(1'b1, 1'b1, 1'b0, 1, r);
    checks++;
    if (sw.dig_clr !== 1'b1 || sw.running !== 1'b0) begin
      errors++;
      $display("FAIL release_clr got clr=%b run=%b required 1 0", sw.dig_clr, sw.running);
    end
    wait_until(r);
    checks++;
    if (sw.running !== 1'b1 || sw.lap_hold !== 1'b0) begin
      errors++;
      $display("FAIL start_lap_prio got run=%b lap=%b required 1 0", sw.running, sw.lap_hold);
    end
    next_tick = r + 4;
    push_ticks(r + 8);
    wait_until(r + 10);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = '0;
      o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL async_events got cyc=%0d ena=%b ovf=%b clr=%b required cyc=%0d ena=%b ovf=%b clr=%b",
                 o.cyc, o.ena, o.ovf, o.clr, e.cyc, e.ena, e.ovf, e.clr);
      end
    end
  endtask

  initial begin
    sw.btn_start = 1'b0;
    sw.btn_lap   = 1'b0;
    sw.btn_reset = 1'b0;
    sw.tc        = 4'b0000;
    test_reset();
    test_run();
    test_carry();
    test_pause();
    test_lap();
    test_reset_btn();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
